// File: rtl/isa_pkg.sv
// Shared ISA constants and the program-loader state encoding.
package isa_pkg;

    localparam int INSTR_W        = 9;
    localparam int LOAD_HDR_BYTES = 2;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_LO,
        LD_LEN_HI,
        LD_W_LO,
        LD_W_HI,
        LD_CHK,
        LD_DONE,
        LD_ERR
    } load_state_t;

    function automatic logic ld_is_busy(load_state_t s);
        return (s == LD_LEN_LO) || (s == LD_LEN_HI) || (s == LD_W_LO) ||
               (s == LD_W_HI)   || (s == LD_CHK);
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Byte-serial program loader: assembles 9-bit words, writes them from address 0
// upward and checks a trailing XOR checksum over the header and payload.
//
// state     | meaning
// ----------+-----------------------------------------------
// LD_IDLE   | waiting for the first start pulse
// LD_LEN_LO | expecting the low byte of the word count N
// LD_LEN_HI | expecting the high byte of N
// LD_W_LO   | expecting instr[7:0]
// LD_W_HI   | expecting {7'b0, instr[8]}; write issued next cycle
// LD_CHK    | expecting the checksum byte
// LD_DONE   | load finished, checksum matched (sticky)
// LD_ERR    | load aborted or checksum mismatch (sticky)
module instr_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [ADDR_W-1:0]  word_count
);

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    load_state_t state, state_nxt;

    logic [7:0]  len_lo;
    logic [7:0]  word_lo;
    logic [7:0]  chk_acc;
    logic [15:0] words_left;

    logic        accept;
    logic        can_start;
    logic [16:0] n_full;
    logic        len_zero;
    logic        len_over;
    logic        hi_bad;
    logic        last_word;

    assign accept    = byte_valid && byte_ready;
    assign can_start = start && ((state == LD_IDLE) || (state == LD_DONE) || (state == LD_ERR));
    assign n_full    = {1'b0, byte_in, len_lo};
    assign len_zero  = (n_full == 17'd0);
    assign len_over  = (33'(n_full) > MAX_WORDS);
    assign hi_bad    = |byte_in[7:1];
    assign last_word = (words_left == 16'd1);

    assign busy       = ld_is_busy(state);
    assign byte_ready = busy;
    assign done       = (state == LD_DONE);
    assign error      = (state == LD_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LD_IDLE, LD_DONE, LD_ERR: begin
                if (start) state_nxt = LD_LEN_LO;
            end
            LD_LEN_LO: begin
                if (accept) state_nxt = LD_LEN_HI;
            end
            LD_LEN_HI: begin
                if (accept) begin
                    if (len_zero)      state_nxt = LD_CHK;
                    else if (len_over) state_nxt = LD_ERR;
                    else               state_nxt = LD_W_LO;
                end
            end
            LD_W_LO: begin
                if (accept) state_nxt = LD_W_HI;
            end
            LD_W_HI: begin
                if (accept) begin
                    if (hi_bad)         state_nxt = LD_ERR;
                    else if (last_word) state_nxt = LD_CHK;
                    else                state_nxt = LD_W_LO;
                end
            end
            LD_CHK: begin
                if (accept) state_nxt = (byte_in == chk_acc) ? LD_DONE : LD_ERR;
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    // Write strobe is a registered pulse so the write lands one cycle after the W_HI byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo     <= '0;
            word_lo    <= '0;
            chk_acc    <= '0;
            words_left <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            word_count <= '0;
        end else begin
            wr_en <= 1'b0;
            if (can_start) begin
                word_count <= '0;
                chk_acc    <= '0;
            end
            if (accept && (state != LD_CHK)) begin
                chk_acc <= chk_acc ^ byte_in;
            end
            if (accept) begin
                case (state)
                    LD_LEN_LO: len_lo     <= byte_in;
                    LD_LEN_HI: words_left <= {byte_in, len_lo};
                    LD_W_LO:   word_lo    <= byte_in;
                    LD_W_HI: begin
                        if (!hi_bad) begin
                            wr_en      <= 1'b1;
                            wr_data    <= {byte_in[0], word_lo};
                            wr_addr    <= word_count;
                            word_count <= word_count + ADDR_W'(1);
                            words_left <= words_left - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Table-driven bench for instr_loader with a write scoreboard.
module tb_instr_loader;
    import isa_pkg::*;

    localparam int ADDR_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [7:0]         byte_in = 8'h00;
    logic               byte_valid = 1'b0;
    logic               byte_ready;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic               busy;
    logic               done;
    logic               error;
    logic [ADDR_W-1:0]  word_count;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [8:0]  data;
    } wr_exp_t;

    typedef struct {
        string       name;
        logic [7:0]  bytes [8];
        int          nbytes;
        int          nwr;
        logic [15:0] wa [2];
        logic [8:0]  wd [2];
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_wc;
    } vec_t;

    wr_exp_t sb_q[$];
    vec_t    vecs[5];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            wr_exp_t e;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h", wr_addr, wr_data);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int cnt = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: byte %0h ready %0b expected 1", b, byte_ready);
        end
        @(negedge clk);
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic push_writes(input vec_t v);
        wr_exp_t e;
        for (int k = 0; k < v.nwr; k++) begin
            e.addr = v.wa[k];
            e.data = v.wd[k];
            sb_q.push_back(e);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit gap, input int inject_at);
        push_writes(v);
        pulse_start();
        for (int i = 0; i < v.nbytes; i++) begin
            if (i == inject_at) start = 1'b1;
            send_byte(v.bytes[i], gap);
            start = 1'b0;
        end
        byte_valid = 1'b0;
        check({v.name, "_done"}, 32'(done), 32'(v.exp_done));
        check({v.name, "_error"}, 32'(error), 32'(v.exp_err));
        check({v.name, "_word_count"}, 32'(word_count), 32'(v.exp_wc));
        check({v.name, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({v.name, "_busy"}, 32'(busy), 32'd0);
        check({v.name, "_pending_writes"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0].name = "load2"; vecs[0].nbytes = 7; vecs[0].nwr = 2;
        vecs[0].bytes = '{8'h02, 8'h00, 8'h78, 8'h01, 8'h00, 8'h00, 8'h7B, 8'h00};
        vecs[0].wa = '{16'd0, 16'd1}; vecs[0].wd = '{9'h178, 9'h000};
        vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0; vecs[0].exp_wc = 16'd2;

        vecs[1] = vecs[0];
        vecs[1].name = "badchk"; vecs[1].bytes[6] = 8'h7A;
        vecs[1].exp_done = 1'b0; vecs[1].exp_err = 1'b1;

        vecs[2].name = "reserved"; vecs[2].nbytes = 4; vecs[2].nwr = 0;
        vecs[2].bytes = '{8'h01, 8'h00, 8'h30, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2].wa = '{16'd0, 16'd0}; vecs[2].wd = '{9'h000, 9'h000};
        vecs[2].exp_done = 1'b0; vecs[2].exp_err = 1'b1; vecs[2].exp_wc = 16'd0;

        vecs[3].name = "zero_len"; vecs[3].nbytes = 3; vecs[3].nwr = 0;
        vecs[3].bytes = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[3].wa = '{16'd0, 16'd0}; vecs[3].wd = '{9'h000, 9'h000};
        vecs[3].exp_done = 1'b1; vecs[3].exp_err = 1'b0; vecs[3].exp_wc = 16'd0;

        vecs[4].name = "max_word"; vecs[4].nbytes = 5; vecs[4].nwr = 1;
        vecs[4].bytes = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
        vecs[4].wa = '{16'd0, 16'd0}; vecs[4].wd = '{9'h1FF, 9'h000};
        vecs[4].exp_done = 1'b1; vecs[4].exp_err = 1'b0; vecs[4].exp_wc = 16'd1;

        #1;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_error", 32'({done, error}), 32'd0);
        check("rst_wr", 32'({wr_en, wr_addr, wr_data}), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], 1'b0, -1);
        end

        // Gapped stream with a start pulse landing mid-load.
        begin
            vec_t v;
            v = vecs[0];
            v.name = "gapped";
            run_vec(v, 1'b1, 3);
        end

        // Reset while the second word is half received; the first write has landed.
        begin
            wr_exp_t e;
            e.addr = 16'd0;
            e.data = 9'h178;
            sb_q.push_back(e);
            pulse_start();
            send_byte(8'h02, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'h78, 1'b0);
            send_byte(8'h01, 1'b0);
            send_byte(8'h00, 1'b0);
            byte_valid = 1'b0;
            check("mid_busy", 32'(busy), 32'd1);
            check("mid_word_count", 32'(word_count), 32'd1);
            check("mid_sb_drained", 32'(sb_q.size()), 32'd0);
            #1;
            rst_n = 1'b0;
            #1;
            check("arst_ready_busy", 32'({byte_ready, busy}), 32'd0);
            check("arst_done_error", 32'({done, error}), 32'd0);
            check("arst_wr", 32'({wr_en, wr_addr, wr_data}), 32'd0);
            check("arst_word_count", 32'(word_count), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            begin
                vec_t v;
                v = vecs[0];
                v.name = "after_reset";
                run_vec(v, 1'b0, -1);
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
